// File: rtl/multi_billing.sv
// Car-wash program billing: price lookup, BCD display and balance charging.
// A single FSM walks IDLE -> CONV -> SHOW -> (CONV) -> PAID.
module multi_billing #(
    parameter int NUM_MODES = 4,
    parameter int PRICE_W   = 12,
    localparam int MODE_W   = (NUM_MODES < 2) ? 1 : $clog2(NUM_MODES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          on,
    input  logic [MODE_W-1:0]             mode,
    input  logic [NUM_MODES*PRICE_W-1:0]  price_tbl,
    input  logic [PRICE_W-1:0]            bal,
    input  logic                          confirm,
    input  logic                          cancel,
    output logic [PRICE_W-1:0]            bal_new,
    output logic                          next,
    output logic                          deny,
    output logic [15:0]                   digits,
    output logic [7:0]                    st_light
);

    localparam int CNT_W = $clog2(PRICE_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRICE_W - 1);
    localparam logic [15:0] BLANK4 = 16'hBBBB;

    // State encoding doubles as the one-hot LED pattern.
    typedef enum logic [7:0] {
        IDLE = 8'h01,
        CONV = 8'h20,
        SHOW = 8'h40,
        PAID = 8'h80
    } state_t;

    state_t             state;
    logic [PRICE_W-1:0] price;
    logic [MODE_W-1:0]  cur_mode;
    logic [PRICE_W-1:0] sh;
    logic [15:0]        bcd;
    logic [CNT_W-1:0]   cnt;
    logic               paid_conv;
    logic               armed;

    logic [MODE_W-1:0]  mode_eff;
    logic [PRICE_W-1:0] sel_price;
    logic [15:0]        bcd_adj;
    logic [16:0]        bcd_step;

    assign st_light = state;

    // Blank leading zeros, keep d0, saturate anything past four digits.
    function automatic logic [15:0] to_digits(input logic [16:0] b);
        logic [15:0] d;
        d = b[15:0];
        if (b[16]) begin
            d = 16'h9999;
        end else if (d[15:12] == 4'd0) begin
            d[15:12] = 4'hB;
            if (d[11:8] == 4'd0) begin
                d[11:8] = 4'hB;
                if (d[7:4] == 4'd0) d[7:4] = 4'hB;
            end
        end
        return d;
    endfunction

    // Mode sanitising, price lookup and one double-dabble step.
    always_comb begin
        mode_eff  = (32'(mode) < NUM_MODES) ? mode : '0;
        sel_price = price_tbl[mode_eff*PRICE_W +: PRICE_W];
        bcd_adj   = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        // A prefix can only reach the fifth digit on the final shift.
        bcd_step = {bcd_adj, sh[PRICE_W-1]};
    end

    // Billing FSM with registered display, pulses and balance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            digits    <= BLANK4;
            bal_new   <= '0;
            next      <= 1'b0;
            deny      <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
            bcd       <= '0;
            price     <= '0;
            cur_mode  <= '0;
            paid_conv <= 1'b0;
            armed     <= 1'b1;
        end else begin
            next <= 1'b0;
            deny <= 1'b0;
            if (!confirm) armed <= 1'b1;
            if (!on) begin
                state  <= IDLE;
                digits <= BLANK4;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        price     <= sel_price;
                        cur_mode  <= mode_eff;
                        sh        <= sel_price;
                        bcd       <= '0;
                        cnt       <= '0;
                        paid_conv <= 1'b0;
                        state     <= CONV;
                    end
                    CONV: begin
                        if (!paid_conv && mode_eff != cur_mode) begin
                            price    <= sel_price;
                            cur_mode <= mode_eff;
                            sh       <= sel_price;
                            bcd      <= '0;
                            cnt      <= '0;
                        end else begin
                            sh  <= {sh[PRICE_W-2:0], 1'b0};
                            bcd <= bcd_step[15:0];
                            cnt <= cnt + 1'b1;
                            if (cnt == LAST) begin
                                digits <= to_digits(bcd_step);
                                cnt    <= '0;
                                state  <= paid_conv ? PAID : SHOW;
                            end
                        end
                    end
                    SHOW: begin
                        if (cancel) begin
                            state  <= IDLE;
                            digits <= BLANK4;
                        end else if (mode_eff != cur_mode) begin
                            price    <= sel_price;
                            cur_mode <= mode_eff;
                            sh       <= sel_price;
                            bcd      <= '0;
                            cnt      <= '0;
                            state    <= CONV;
                        end else if (confirm && armed) begin
                            armed <= 1'b0;
                            if (bal >= price) begin
                                bal_new   <= bal - price;
                                next      <= 1'b1;
                                sh        <= bal - price;
                                bcd       <= '0;
                                cnt       <= '0;
                                paid_conv <= 1'b1;
                                state     <= CONV;
                            end else begin
                                deny <= 1'b1;
                            end
                        end
                    end
                    PAID: begin
                        if (cancel) begin
                            state  <= IDLE;
                            digits <= BLANK4;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_billing.sv
// Directed and randomized checks of multi_billing against a decimal model.
// Four programs, 12-bit prices.
module tb_multi_billing;

    logic        clk = 1'b0;
    logic        rst;
    logic        on;
    logic [1:0]  mode;
    logic [47:0] price_tbl;
    logic [11:0] bal;
    logic        confirm;
    logic        cancel;
    logic [11:0] bal_new;
    logic        next;
    logic        deny;
    logic [15:0] digits;
    logic [7:0]  st_light;

    int checks = 0;
    int errors = 0;
    int exp_bal = 0;
    int prices [4];

    multi_billing #(.NUM_MODES(4), .PRICE_W(12)) dut (
        .clk(clk), .rst(rst), .on(on), .mode(mode),
        .price_tbl(price_tbl), .bal(bal), .confirm(confirm),
        .cancel(cancel), .bal_new(bal_new), .next(next),
        .deny(deny), .digits(digits), .st_light(st_light)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [7:0] s, input string tag);
        int n;
        n = 0;
        while (st_light !== s && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(st_light), 32'(s));
    endtask

    // Decimal display the way a person would write it on the panel.
    function automatic logic [15:0] disp(input int v);
        int x;
        logic [15:0] d;
        x = (v > 9999) ? 9999 : v;
        d = {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
        if (x < 1000) d[15:12] = 4'hB;
        if (x < 100)  d[11:8]  = 4'hB;
        if (x < 10)   d[7:4]   = 4'hB;
        return d;
    endfunction

    task automatic load_prices();
        for (int i = 0; i < 4; i++)
            price_tbl[i*12 +: 12] = 12'(prices[i]);
    endtask

    initial begin
        int dn;
        int nn;
        int p;
        int b;
        int m;
        rst = 1'b1; on = 1'b0; mode = 2'd0; bal = '0;
        confirm = 1'b0; cancel = 1'b0;
        prices[0] = 100; prices[1] = 250; prices[2] = 400; prices[3] = 600;
        load_prices();

        // reset
        repeat (2) tick();
        check("rst_digits", 32'(digits), 32'(16'hBBBB));
        check("rst_bal", 32'(bal_new), 32'(0));
        check("rst_light", 32'(st_light), 32'(8'h01));
        check("rst_pulses", 32'({next, deny}), 32'(0));
        rst = 1'b0;
        tick();
        check("idle_off", 32'(st_light), 32'(8'h01));

        // quote program 1
        on = 1'b1; mode = 2'd1;
        tick();
        check("enter_conv", 32'(st_light), 32'(8'h20));
        repeat (11) tick();
        check("conv_len", 32'(st_light), 32'(8'h20));
        check("conv_hold", 32'(digits), 32'(16'hBBBB));
        tick();
        check("show_250", 32'(st_light), 32'(8'h40));
        check("digits_250", 32'(digits), 32'(disp(250)));

        // pay 300 for 250
        bal = 12'd300; confirm = 1'b1;
        tick();
        exp_bal = 50;
        check("next_pulse", 32'({next, deny}), 32'(2'b10));
        check("bal_50", 32'(bal_new), 32'(exp_bal));
        confirm = 1'b0;
        tick();
        check("next_once", 32'(next), 32'(0));
        check("hold_during_conv", 32'(digits), 32'(disp(250)));
        repeat (11) tick();
        check("paid_state", 32'(st_light), 32'(8'h80));
        check("digits_50", 32'(digits), 32'(disp(50)));
        confirm = 1'b1;
        tick();
        check("paid_ignores_confirm", 32'({st_light, next}), 32'({8'h80, 1'b0}));
        confirm = 1'b0;

        // insufficient balance, confirm held
        cancel = 1'b1;
        tick();
        check("cancel_paid", 32'({st_light, digits}), 32'({8'h01, 16'hBBBB}));
        cancel = 1'b0; mode = 2'd2;
        wait_state(8'h40, "wait_show_400");
        check("digits_400", 32'(digits), 32'(disp(400)));
        bal = 12'd399; confirm = 1'b1;
        dn = 0; nn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            dn += int'(deny);
            nn += int'(next);
            check("deny_no_next", 32'(next & deny), 32'(0));
        end
        check("deny_count", 32'(dn), 32'(1));
        check("deny_next_count", 32'(nn), 32'(0));
        check("deny_state", 32'(st_light), 32'(8'h40));
        check("deny_bal", 32'(bal_new), 32'(exp_bal));
        confirm = 1'b0;
        tick();
        bal = 12'd400; confirm = 1'b1;
        tick();
        exp_bal = 0;
        check("exact_next", 32'({next, deny}), 32'(2'b10));
        check("exact_bal", 32'(bal_new), 32'(exp_bal));
        confirm = 1'b0;
        wait_state(8'h80, "wait_paid_0");
        check("digits_0", 32'(digits), 32'(16'hBBB0));

        // mode change mid-conversion, then power drop
        cancel = 1'b1;
        tick();
        cancel = 1'b0; mode = 2'd1;
        tick();
        repeat (4) tick();
        check("mid_conv", 32'(st_light), 32'(8'h20));
        mode = 2'd3;
        wait_state(8'h40, "wait_show_600");
        check("digits_600", 32'(digits), 32'(disp(600)));
        mode = 2'd1;
        tick();
        check("reconv", 32'(st_light), 32'(8'h20));
        repeat (3) tick();
        on = 1'b0;
        tick();
        check("off_idle", 32'({st_light, digits}), 32'({8'h01, 16'hBBBB}));
        check("off_keeps_bal", 32'(bal_new), 32'(exp_bal));

        // confirm and cancel together
        on = 1'b1; mode = 2'd0;
        wait_state(8'h40, "wait_show_100");
        check("digits_100", 32'(digits), 32'(disp(100)));
        bal = 12'd1000; confirm = 1'b1; cancel = 1'b1;
        tick();
        check("cancel_wins", 32'({st_light, next, deny}), 32'({8'h01, 2'b00}));
        confirm = 1'b0; cancel = 1'b0;
        wait_state(8'h40, "wait_show_100b");
        confirm = 1'b1;
        tick();
        exp_bal = 900;
        check("bal_900", 32'({next, bal_new}), 32'({1'b1, 12'd900}));
        confirm = 1'b0;
        wait_state(8'h80, "wait_paid_900");
        check("digits_900", 32'(digits), 32'(disp(900)));
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_state(8'h40, "wait_show_100c");

        // reset on the confirm cycle
        confirm = 1'b1; rst = 1'b1;
        tick();
        exp_bal = 0;
        check("rst_confirm_next", 32'(next), 32'(0));
        check("rst_confirm_bal", 32'(bal_new), 32'(exp_bal));
        check("rst_confirm_state", 32'({st_light, digits}), 32'({8'h01, 16'hBBBB}));
        rst = 1'b0; confirm = 1'b0;

        // randomized quotes and charges
        for (int it = 0; it < 24; it++) begin
            on = 1'b0;
            tick();
            for (int i = 0; i < 4; i++) prices[i] = int'($urandom_range(0, 4095));
            load_prices();
            m = int'($urandom_range(0, 3));
            mode = 2'(m);
            p = prices[m];
            on = 1'b1;
            wait_state(8'h40, "rnd_show");
            check("rnd_quote", 32'(digits), 32'(disp(p)));
            case ($urandom_range(0, 2))
                0: b = p;
                1: b = (p > 0) ? p - 1 : int'($urandom_range(0, 4095));
                default: b = int'($urandom_range(0, 4095));
            endcase
            bal = 12'(b);
            confirm = 1'b1;
            tick();
            if (b >= p) begin
                exp_bal = b - p;
                check("rnd_next", 32'({next, deny}), 32'(2'b10));
                check("rnd_bal", 32'(bal_new), 32'(exp_bal));
                confirm = 1'b0;
                wait_state(8'h80, "rnd_paid");
                check("rnd_rem", 32'(digits), 32'(disp(exp_bal)));
            end else begin
                check("rnd_deny", 32'({next, deny}), 32'(2'b01));
                check("rnd_keep", 32'(bal_new), 32'(exp_bal));
                confirm = 1'b0;
                tick();
                check("rnd_stay", 32'(st_light), 32'(8'h40));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_billing.md
MULTI_BILLING -- requirements
Module: multi_billing

Interface
REQ-001 The block SHALL have parameter NUM_MODES, default 4, meaning the number of wash programs priced (2..16).
REQ-002 The block SHALL have parameter PRICE_W, default 12, meaning the width of prices and balances (4..14).
REQ-003 The block SHALL have localparam MODE_W = max(1, clog2(NUM_MODES)).
REQ-004 The block SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port on  input  1  meaning machine powered/billing enabled.
REQ-007 The block SHALL have port mode  input  MODE_W  meaning the selected program; values >= NUM_MODES are treated as 0.
REQ-008 The block SHALL have port price_tbl  input  NUM_MODES*PRICE_W  meaning the price table, with entry i at bits [i*PRICE_W +: PRICE_W].
REQ-009 The block SHALL have port bal  input  PRICE_W  meaning the customer balance, sampled only on accepted confirm.
REQ-010 The block SHALL have port confirm  input  1  meaning the pay request, a level sampled each cycle.
REQ-011 The block SHALL have port cancel  input  1  meaning abort quote, return to idle.
REQ-012 The block SHALL have port bal_new  output  PRICE_W  meaning the balance after the last successful charge.
REQ-013 The block SHALL have port next  output  1  meaning a one-cycle pulse when a charge is accepted.
REQ-014 The block SHALL have port deny  output  1  meaning a one-cycle pulse when a charge is refused for insufficient balance.
REQ-015 The block SHALL have port digits  output  16  meaning 4 BCD digits {d3,d2,d1,d0}, with 4'hB = blank, for the existing 4-digit scanner.
REQ-016 The block SHALL have port st_light  output  8  meaning one-hot state LEDs.

Function
REQ-017 The block SHALL implement FSM states IDLE, CONV, SHOW, PAID, with st_light = 8'h01, 8'h20, 8'h40, 8'h80 respectively.
REQ-018 In IDLE with on=1, the block SHALL latch price = price_tbl[mode] and cur_mode = mode, and go to CONV next cycle.
REQ-019 CONV SHALL run a sequential binary-to-BCD (double-dabble) conversion of the latched value, one bit per cycle, exactly PRICE_W cycles, and then go to SHOW (or PAID when converting a remainder).
REQ-020 digits SHALL hold its previous value during CONV and update atomically on the CONV exit cycle.
REQ-021 Leading zeros SHALL be blanked (4'hB); d0 SHALL never be blank, so 0 displays as BBB0.
REQ-022 Values > 9999 SHALL display 9999 (saturate).
REQ-023 In SHOW, if mode != cur_mode, the block SHALL re-latch the price and re-enter CONV next cycle.
REQ-024 A mode change during CONV SHALL restart the conversion with the new price; the bit counter resets.
REQ-025 In SHOW with confirm=1 and bal >= price, the block SHALL register bal_new = bal - price and pulse next=1 in the following cycle, then convert bal_new in CONV and go to PAID.
REQ-026 In SHOW with confirm=1 and bal < price, the block SHALL pulse deny=1 for one cycle, keep bal_new unchanged, and remain in SHOW.
REQ-027 The price/balance comparison SHALL be unsigned PRICE_W bit; bal == price is accepted, giving bal_new = 0.
REQ-028 confirm held high SHALL charge only once: after deny, a new evaluation requires confirm to return low for at least one cycle.
REQ-029 In SHOW, cancel=1 SHALL go to IDLE and blank digits next cycle; cancel has priority over confirm in the same cycle.
REQ-030 PAID SHALL hold the remainder display until on=0 or cancel=1, then go to IDLE; confirm SHALL be ignored in PAID.
REQ-031 on=0 in any state SHALL force IDLE next cycle, abort any conversion, set digits = BBBB, and keep bal_new.
REQ-032 next and deny SHALL never be high in the same cycle.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL enter IDLE with digits=16'hBBBB, bal_new=0, next=0, deny=0, st_light=8'h01, and the conversion counter cleared.
REQ-034 rst SHALL override all inputs, including mid-CONV and on the same cycle as confirm.

Verification (PRICE_W=12, NUM_MODES=4, prices 100/250/400/600)
REQ-035 The bench SHALL apply rst for 2 cycles -> digits=BBBB, bal_new=0, st_light=01, next=deny=0.
REQ-036 The bench SHALL apply on=1, mode=1 -> 1 cycle IDLE, 12 cycles CONV, then digits=B250 and st_light=40.
REQ-037 The bench SHALL apply bal=300 and pulse confirm in SHOW -> next high one cycle, bal_new=50, and digits=BB50 in PAID after 12 cycles.
REQ-038 The bench SHALL apply mode=2, bal=399 and hold confirm 5 cycles -> exactly one deny pulse, bal_new unchanged, state SHOW; with bal=400 -> next, bal_new=0, digits=BBB0.
REQ-039 The bench SHALL change mode 1->3 at cycle 5 of CONV -> conversion restarts and final digits=B600; on dropping mid-CONV -> IDLE next cycle, digits=BBBB.
REQ-040 The bench SHALL assert confirm and cancel in the same SHOW cycle -> IDLE with no next and no deny; rst asserted on the confirm cycle -> no next pulse, bal_new=0.
